dmem_write_buffer: RTL and testbench



---
 rtl/dmem_write_buffer.sv | 128 ++++++++++++
 tb/tb_dmem_write_buffer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer: posted-store write buffer between the core memory stage
// and a single-write-port data memory. Stores are accepted in one cycle into a
// FIFO and drained to memory while mem_ready is high. Loads read memory
// combinationally. If a buffered store to the same word exists, the newest
// matching entry is forwarded to the load instead.
// Optional feature: define DMEM_WBUF_COALESCE_EN. A store to the same word as
// the youngest entry then overwrites that entry's data instead of pushing.
module dmem_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Empty,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  logic [DEPTH-1:0] valid;
  logic [29:0]      entry_addr [DEPTH];
  logic [31:0]      entry_data [DEPTH];
  ptr_t             head;
  ptr_t             tail;
  cnt_t             count;

  logic        full;
  logic        push;
  logic        pop;
  logic        coalesce;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  assign full   = (count == cnt_t'(DEPTH));
  assign Empty  = (count == '0);
  assign mem_we = ~Empty;
  assign pop    = mem_we & mem_ready;

`ifdef DMEM_WBUF_COALESCE_EN
  ptr_t young;
  assign young    = tail - ptr_t'(1);
  // The youngest entry may absorb the store unless it is draining this cycle.
  assign coalesce = MemWrite & ~Empty & valid[young] &
                    (entry_addr[young] == Addr[31:2]) &
                    ~(pop & (head == young));
`else
  assign coalesce = 1'b0;
`endif

  // A store only waits when the buffer is full and nothing leaves this cycle.
  assign Stall = MemWrite & full & ~mem_ready & ~coalesce;
  assign push  = MemWrite & ~Stall & ~coalesce;

  // Empty buffer drives zeros so stale entries never show on the write port.
  assign mem_waddr = mem_we ? {entry_addr[head], 2'b00} : '0;
  assign mem_wdata = mem_we ? entry_data[head] : '0;
  assign mem_raddr = Addr;

  // Forwarding search: walk the live entries oldest to newest so the last hit is the newest.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((cnt_t'(i) < count) && valid[head + ptr_t'(i)] &&
          (entry_addr[head + ptr_t'(i)] == Addr[31:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = entry_data[head + ptr_t'(i)];
      end
    end
  end

  // Load data: forwarded store data wins over memory; a store cycle returns raw memory data.
  assign ReadData = (MemRead & ~MemWrite & fwd_hit) ? fwd_data : mem_rdata;

  // Control state: pointers, occupancy and valid bits.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      // NOTE: non-blocking assignments here; when full with pop and push, head == tail
      // and the later set of valid[tail] overrides the clear of valid[head].
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + ptr_t'(1);
      end
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + ptr_t'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload storage; written on push (or coalesce), never read while invalid.
  // NOTE: the payload arrays are deliberately not reset; valid bits and count guard them.
  always_ff @(posedge CLK) begin
    if (push) begin
      entry_addr[tail] <= Addr[31:2];
      entry_data[tail] <= WriteData;
    end
`ifdef DMEM_WBUF_COALESCE_EN
    else if (coalesce) begin
      entry_data[young] <= WriteData;
    end
`endif
  end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Self-checking bench for dmem_write_buffer: directed vector table, hand-written
// multi-cycle corner cases, and a randomized phase. A queue-based reference model
// supplies the expected outputs throughout.
module tb_dmem_write_buffer;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        MemWrite, MemRead, mem_ready;
  logic [31:0] Addr, WriteData, mem_rdata;
  logic [31:0] ReadData, mem_waddr, mem_wdata, mem_raddr;
  logic        Stall, Empty, mem_we;

  dmem_write_buffer #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .Reset(Reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
    .Empty(Empty), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of posted stores, oldest at index 0.
  typedef struct { logic [29:0] a; logic [31:0] d; } ent_t;
  ent_t q[$];

`ifdef DMEM_WBUF_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  function automatic logic m_coal();
    if (!COAL || !MemWrite || q.size() == 0) return 1'b0;
    if (q[q.size()-1].a != Addr[31:2]) return 1'b0;
    return !(mem_ready && q.size() == 1);
  endfunction

  function automatic logic m_stall();
    return MemWrite && q.size() == DEPTH && !mem_ready && !m_coal();
  endfunction

  function automatic logic [31:0] m_rdata();
    logic [31:0] r = mem_rdata;
    if (MemRead && !MemWrite)
      for (int i = 0; i < q.size(); i++)
        if (q[i].a == Addr[31:2]) r = q[i].d;
    return r;
  endfunction

  // Drive one cycle's inputs shortly after the rising edge, then let them settle.
  task automatic apply(input logic we, input logic rd, input logic [31:0] a,
                       input logic [31:0] wd, input logic rdy, input logic [31:0] rdat);
    MemWrite = we; MemRead = rd; Addr = a; WriteData = wd;
    mem_ready = rdy; mem_rdata = rdat;
    #2;
  endtask

  // Compare every output against the model for the current cycle.
  task automatic model_check();
    logic emp = (q.size() == 0) || !Reset;
    check("stall", {31'b0, Stall}, {31'b0, Reset ? m_stall() : 1'b0});
    check("empty", {31'b0, Empty}, {31'b0, emp});
    check("mem_we", {31'b0, mem_we}, {31'b0, !emp});
    check("mem_waddr", mem_waddr, emp ? 32'h0 : {q[0].a, 2'b00});
    check("mem_wdata", mem_wdata, emp ? 32'h0 : q[0].d);
    check("read_data", ReadData, Reset ? m_rdata() : mem_rdata);
    check("mem_raddr", mem_raddr, Addr);
  endtask

  // Advance across one rising edge and update the model by the buffer rules.
  task automatic advance();
    logic pop, coal, push;
    ent_t e;
    pop  = Reset && q.size() != 0 && mem_ready;
    coal = Reset && m_coal();
    push = Reset && MemWrite && !m_stall() && !coal;
    @(posedge CLK);
    if (!Reset) q.delete();
    else begin
      if (coal) begin e = q[q.size()-1]; e.d = WriteData; q[q.size()-1] = e; end
      if (pop) void'(q.pop_front());
      if (push) begin e.a = Addr[31:2]; e.d = WriteData; q.push_back(e); end
    end
    #1;
  endtask

  task automatic cyc(input logic we, input logic rd, input logic [31:0] a,
                     input logic [31:0] wd, input logic rdy, input logic [31:0] rdat);
    apply(we, rd, a, wd, rdy, rdat);
    model_check();
    advance();
  endtask

  task automatic drain_all();
    for (int k = 0; k < 3 * DEPTH && q.size() != 0; k++) cyc(0, 0, 0, 0, 1, $urandom);
    check("drain_bound", q.size(), 0);
  endtask

  typedef struct {
    logic we, rd; logic [31:0] addr, wd; logic rdy; logic [31:0] rdata;
    logic xs, xe, xw; logic [31:0] xwa, xwd, xrd;
  } vec_t;

  function automatic vec_t mk(logic we, logic rd, logic [31:0] a, logic [31:0] wd, logic rdy,
                              logic [31:0] rdat, logic xs, logic xe, logic xw,
                              logic [31:0] xwa, logic [31:0] xwd, logic [31:0] xrd);
    vec_t v;
    v.we = we; v.rd = rd; v.addr = a; v.wd = wd; v.rdy = rdy; v.rdata = rdat;
    v.xs = xs; v.xe = xe; v.xw = xw; v.xwa = xwa; v.xwd = xwd; v.xrd = xrd;
    return v;
  endfunction

  initial begin
    vec_t vt[18];
    logic [31:0] c_head;
    int drains;
    logic [31:0] last_d;

    c_head = COAL ? 32'd2 : 32'd1;
    // Store then drain, FIFO fill, full stall and release, forwarding of newest entry.
    vt[0]  = mk(1, 0, 32'h100, 32'hAAAA5555, 1, 32'h11, 0, 1, 0, 32'h0,   32'h0,        32'h11);
    vt[1]  = mk(0, 1, 32'h100, 32'h0,        1, 32'h22, 0, 0, 1, 32'h100, 32'hAAAA5555, 32'hAAAA5555);
    vt[2]  = mk(0, 1, 32'h100, 32'h0,        1, 32'h33, 0, 1, 0, 32'h0,   32'h0,        32'h33);
    vt[3]  = mk(1, 0, 32'h0,   32'hA0,       0, 32'h5,  0, 1, 0, 32'h0,   32'h0,        32'h5);
    vt[4]  = mk(1, 0, 32'h4,   32'hA1,       0, 32'h5,  0, 0, 1, 32'h0,   32'hA0,       32'h5);
    vt[5]  = mk(1, 0, 32'h8,   32'hA2,       0, 32'h5,  0, 0, 1, 32'h0,   32'hA0,       32'h5);
    vt[6]  = mk(1, 0, 32'hC,   32'hA3,       0, 32'h5,  0, 0, 1, 32'h0,   32'hA0,       32'h5);
    vt[7]  = mk(1, 0, 32'h10,  32'hA4,       0, 32'h5,  1, 0, 1, 32'h0,   32'hA0,       32'h5);
    vt[8]  = mk(1, 0, 32'h10,  32'hA4,       1, 32'h5,  0, 0, 1, 32'h0,   32'hA0,       32'h5);
    vt[9]  = mk(0, 0, 32'h0,   32'h0,        1, 32'h5,  0, 0, 1, 32'h4,   32'hA1,       32'h5);
    vt[10] = mk(0, 0, 32'h0,   32'h0,        1, 32'h5,  0, 0, 1, 32'h8,   32'hA2,       32'h5);
    vt[11] = mk(0, 0, 32'h0,   32'h0,        1, 32'h5,  0, 0, 1, 32'hC,   32'hA3,       32'h5);
    vt[12] = mk(0, 0, 32'h0,   32'h0,        1, 32'h5,  0, 0, 1, 32'h10,  32'hA4,       32'h5);
    vt[13] = mk(0, 0, 32'h0,   32'h0,        1, 32'h5,  0, 1, 0, 32'h0,   32'h0,        32'h5);
    vt[14] = mk(1, 0, 32'h20,  32'h1,        0, 32'h7,  0, 1, 0, 32'h0,   32'h0,        32'h7);
    vt[15] = mk(1, 0, 32'h20,  32'h2,        0, 32'h7,  0, 0, 1, 32'h20,  32'h1,        32'h7);
    vt[16] = mk(0, 1, 32'h20,  32'h0,        0, 32'hDEAD, 0, 0, 1, 32'h20, c_head,      32'h2);
    vt[17] = mk(0, 1, 32'h24,  32'h0,        0, 32'hBEEF, 0, 0, 1, 32'h20, c_head,      32'hBEEF);

    // Reset held low with a store request pending.
    Reset = 1'b0;
    MemWrite = 1; MemRead = 0; Addr = 32'h100; WriteData = 32'h1234;
    mem_ready = 0; mem_rdata = 32'h99;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_empty", {31'b0, Empty}, 32'd1);
    check("rst_stall", {31'b0, Stall}, 32'd0);
    check("rst_waddr", mem_waddr, 32'h0);
    check("rst_rdata", ReadData, 32'h99);
    Reset = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 18; i++) begin
      apply(vt[i].we, vt[i].rd, vt[i].addr, vt[i].wd, vt[i].rdy, vt[i].rdata);
      check($sformatf("vec%0d_stall", i), {31'b0, Stall}, {31'b0, vt[i].xs});
      check($sformatf("vec%0d_empty", i), {31'b0, Empty}, {31'b0, vt[i].xe});
      check($sformatf("vec%0d_mem_we", i), {31'b0, mem_we}, {31'b0, vt[i].xw});
      check($sformatf("vec%0d_waddr", i), mem_waddr, vt[i].xwa);
      check($sformatf("vec%0d_wdata", i), mem_wdata, vt[i].xwd);
      check($sformatf("vec%0d_rdata", i), ReadData, vt[i].xrd);
      model_check();
      advance();
    end
    drain_all();

    // Coalescing corner: two stores to one word with memory not ready.
    cyc(1, 0, 32'h40, 32'h5, 0, 0);
    cyc(1, 0, 32'h40, 32'h6, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    check("coal_head_data", mem_wdata, COAL ? 32'h6 : 32'h5);
    model_check();
    advance();
    drains = 0; last_d = 0;
    for (int k = 0; k < 10 && mem_we; k++) begin
      apply(0, 0, 0, 0, 1, 0);
      drains++; last_d = mem_wdata;
      model_check();
      advance();
    end
    check("coal_drains", drains, COAL ? 32'd1 : 32'd2);
    check("coal_last", last_d, 32'h6);

    // Simultaneous push and pop at count 2, wrapping the pointers twice over.
    cyc(1, 0, 32'h300, 32'h30, 0, 0);
    cyc(1, 0, 32'h304, 32'h31, 0, 0);
    for (int k = 0; k < 2 * DEPTH; k++) begin
      apply(1, 0, 32'h308 + 32'(4 * k), 32'h32 + 32'(k), 1, 0);
      check("pp_count", q.size(), 2);
      check("pp_empty", {31'b0, Empty}, 32'd0);
      check("pp_waddr", mem_waddr, 32'h300 + 32'(4 * k));
      model_check();
      advance();
    end
    drain_all();

    // Asynchronous reset mid-cycle with three entries pending.
    cyc(1, 0, 32'h200, 32'h20, 0, 0);
    cyc(1, 0, 32'h204, 32'h21, 0, 0);
    cyc(1, 0, 32'h208, 32'h22, 0, 0);
    apply(0, 0, 0, 0, 1, 32'h77);
    #2 Reset = 1'b0;
    #1;
    check("mid_rst_empty", {31'b0, Empty}, 32'd1);
    check("mid_rst_mem_we", {31'b0, mem_we}, 32'd0);
    advance();
    cyc(0, 0, 0, 0, 1, 0);
    Reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      apply(0, 1, 32'h204, 0, 1, 32'h55);
      check("post_rst_mem_we", {31'b0, mem_we}, 32'd0);
      check("post_rst_rdata", ReadData, 32'h55);
      model_check();
      advance();
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          32'h1000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
          $urandom, 1'($urandom_range(0, 2) == 0), $urandom);
    end
    drain_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
